// File: rtl/axi_arb_pkg.sv
// Shared encodings and defaults for the cache-to-AXI-bridge arbiter.
// Read and write FSM states are kept as plain constants so they stay compatible with older code.
package axi_arb_pkg;

    localparam int LINE_OFF_W_DFLT = 4;

    localparam logic [1:0] R_IDLE = 2'b00;
    localparam logic [1:0] R_IC   = 2'b01;
    localparam logic [1:0] R_DC   = 2'b10;

    localparam logic W_IDLE = 1'b0;
    localparam logic W_BUSY = 1'b1;

    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

endpackage

// File: rtl/line_hazard_chk.sv
// Read-after-write hazard check for one read master at cache-line granularity.
// This check always blocks a same-line read, whatever the read type.
module line_hazard_chk
    import axi_arb_pkg::*;
#(
    parameter int LINE_OFF_W = LINE_OFF_W_DFLT
) (
    input  logic [31-LINE_OFF_W:0] rd_line_i,
    input  logic                   wr_busy_i,
    input  logic [31-LINE_OFF_W:0] wr_line_i,
    input  logic                   wr_req_i,
    input  logic [31-LINE_OFF_W:0] wr_req_line_i,
    output logic                   hazard_o
);

    // An unaccepted write to the same line also counts as a hazard, so the write goes out first.
    assign hazard_o = wr_busy_i ? (rd_line_i == wr_line_i)
                                : (wr_req_i && (rd_line_i == wr_req_line_i));

endmodule

// File: rtl/cache_axi_arbiter.sv
// Arbitrates icache/dcache reads and dcache writes onto the single request port of the AXI bridge.
// The dcache wins read ties. A read that would pass a pending write to the same line is held back.
module cache_axi_arbiter
    import axi_arb_pkg::*;
#(
    parameter int LINE_OFF_W = LINE_OFF_W_DFLT
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    input  logic         ic_rd_req_i,
    input  logic [2:0]   ic_rd_type_i,
    input  logic [31:0]  ic_rd_addr_i,
    output logic         ic_rd_rdy_o,
    output logic         ic_ret_valid_o,
    output logic         ic_ret_last_o,
    output logic [31:0]  ic_ret_data_o,
    input  logic         dc_rd_req_i,
    input  logic [2:0]   dc_rd_type_i,
    input  logic [31:0]  dc_rd_addr_i,
    output logic         dc_rd_rdy_o,
    output logic         dc_ret_valid_o,
    output logic         dc_ret_last_o,
    output logic [31:0]  dc_ret_data_o,
    input  logic         dc_wr_req_i,
    input  logic [2:0]   dc_wr_type_i,
    input  logic [31:0]  dc_wr_addr_i,
    input  logic [3:0]   dc_wr_wstrb_i,
    input  logic [127:0] dc_wr_data_i,
    output logic         dc_wr_rdy_o,
    output logic         dc_wr_resp_o,
    output logic         rd_req_o,
    output logic [2:0]   rd_type_o,
    output logic [31:0]  rd_addr_o,
    input  logic         rd_rdy_i,
    input  logic         ret_valid_i,
    input  logic         ret_last_i,
    input  logic [31:0]  ret_data_i,
    output logic         wr_req_o,
    output logic [2:0]   wr_type_o,
    output logic [31:0]  wr_addr_o,
    output logic [3:0]   wr_wstrb_o,
    output logic [127:0] wr_data_o,
    input  logic         wr_rdy_i,
    input  logic         wr_resp_i
);

    logic [1:0]              rd_state_q, rd_state_d;
    logic                    wr_state_q, wr_state_d;
    logic [31-LINE_OFF_W:0]  wr_line_q, wr_line_d;
    logic                    ic_haz, dc_haz, ic_ok, dc_ok, live;

    line_hazard_chk #(.LINE_OFF_W(LINE_OFF_W)) u_ic_haz (
        .rd_line_i     (ic_rd_addr_i[31:LINE_OFF_W]),
        .wr_busy_i     (wr_state_q == W_BUSY),
        .wr_line_i     (wr_line_q),
        .wr_req_i      (dc_wr_req_i),
        .wr_req_line_i (dc_wr_addr_i[31:LINE_OFF_W]),
        .hazard_o      (ic_haz)
    );

    line_hazard_chk #(.LINE_OFF_W(LINE_OFF_W)) u_dc_haz (
        .rd_line_i     (dc_rd_addr_i[31:LINE_OFF_W]),
        .wr_busy_i     (wr_state_q == W_BUSY),
        .wr_line_i     (wr_line_q),
        .wr_req_i      (dc_wr_req_i),
        .wr_req_line_i (dc_wr_addr_i[31:LINE_OFF_W]),
        .hazard_o      (dc_haz)
    );

    // Outputs are gated by reset as well as flush, so nothing leaks through while resetn is low.
    assign live  = resetn & ~flush;
    assign dc_ok = dc_rd_req_i & ~dc_haz;
    assign ic_ok = ic_rd_req_i & ~ic_haz;

    always_comb begin
        // NOTE: every signal written in this block gets a default first, so no latch is inferred.
        rd_state_d     = rd_state_q;
        wr_state_d     = wr_state_q;
        wr_line_d      = wr_line_q;
        rd_req_o       = 1'b0;
        rd_type_o      = '0;
        rd_addr_o      = '0;
        ic_rd_rdy_o    = 1'b0;
        dc_rd_rdy_o    = 1'b0;
        ic_ret_valid_o = 1'b0;
        ic_ret_last_o  = 1'b0;
        ic_ret_data_o  = '0;
        dc_ret_valid_o = 1'b0;
        dc_ret_last_o  = 1'b0;
        dc_ret_data_o  = '0;
        wr_req_o       = 1'b0;
        wr_type_o      = '0;
        wr_addr_o      = '0;
        wr_wstrb_o     = '0;
        wr_data_o      = '0;
        dc_wr_rdy_o    = 1'b0;
        dc_wr_resp_o   = 1'b0;

        case (rd_state_q)
            R_IDLE: if (live) begin
                rd_req_o = dc_ok | ic_ok;
                if (dc_ok) begin
                    rd_type_o   = dc_rd_type_i;
                    rd_addr_o   = dc_rd_addr_i;
                    dc_rd_rdy_o = rd_rdy_i;
                end else if (ic_ok) begin
                    rd_type_o   = ic_rd_type_i;
                    rd_addr_o   = ic_rd_addr_i;
                    ic_rd_rdy_o = rd_rdy_i;
                end
                if (rd_req_o && rd_rdy_i) rd_state_d = dc_ok ? R_DC : R_IC;
            end
            R_IC: if (live) begin
                ic_ret_valid_o = ret_valid_i;
                ic_ret_last_o  = ret_last_i;
                ic_ret_data_o  = ret_data_i;
                if (ret_valid_i && ret_last_i) rd_state_d = R_IDLE;
            end
            R_DC: if (live) begin
                dc_ret_valid_o = ret_valid_i;
                dc_ret_last_o  = ret_last_i;
                dc_ret_data_o  = ret_data_i;
                if (ret_valid_i && ret_last_i) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase

        if (wr_state_q == W_IDLE) begin
            if (live) begin
                wr_req_o    = dc_wr_req_i;
                dc_wr_rdy_o = wr_rdy_i;
                if (dc_wr_req_i) begin
                    wr_type_o  = dc_wr_type_i;
                    wr_addr_o  = dc_wr_addr_i;
                    wr_wstrb_o = dc_wr_wstrb_i;
                    wr_data_o  = dc_wr_data_i;
                end
                if (wr_req_o && wr_rdy_i) begin
                    wr_line_d  = dc_wr_addr_i[31:LINE_OFF_W];
                    wr_state_d = W_BUSY;
                end
            end
        end else if (live) begin
            dc_wr_resp_o = wr_resp_i;
            if (wr_resp_i) wr_state_d = W_IDLE;
        end

        if (flush) begin
            rd_state_d = R_IDLE;
            wr_state_d = W_IDLE;
            wr_line_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state_q <= R_IDLE;
            wr_state_q <= W_IDLE;
            wr_line_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            wr_line_q  <= wr_line_d;
        end
    end

endmodule
